// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and default sizes for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Who currently holds a lock on the memory port
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    localparam int DMEM_AW        = 32;
    localparam int DMEM_DW        = 32;
    localparam int DMEM_MAX_BURST = 4;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Combinational 2-way round-robin picker. ptr=0 favours req[0],
//            ptr=1 favours req[1]; a lone request always wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    import dmem_pkg::*;

    // One-hot pick: the pointer only matters when both masters ask
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~ptr);
        gnt[1] = req[1] & (~req[0] |  ptr);
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data memory between the CPU load/store
//            path (m0) and the DMA/loader (m1). Round-robin with bounded
//            lock bursts; read data returned one cycle after the grant.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW        = DMEM_AW,
    parameter int DW        = DMEM_DW,
    parameter int MAX_BURST = DMEM_MAX_BURST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic          m0_lock,
    input  logic          m1_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rd
);

    logic       rr_ptr;
    owner_t     owner;
    logic [3:0] beat_cnt;
    logic       rd_pend;
    logic       rd_tag;

    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       sel;
    logic       sel_we;
    logic       sel_lock;
    owner_t     sel_own;
    logic [3:0] base_cnt;
    logic [4:0] next_cnt;
    logic       lock_ok;

    rr_pick2 u_pick (
        .req (pick_req()),
        .ptr (rr_ptr),
        .gnt (pick_gnt)
    );

    function automatic logic [1:0] pick_req();
        return {m1_req, m0_req};
    endfunction

    // Grant selection: a locked owner that still requests keeps the port,
    // otherwise the round-robin picker decides. Nothing is granted in reset.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            gnt = 2'b00;
        end else if (owner == OWN_M0 && m0_req) begin
            gnt = 2'b01;
        end else if (owner == OWN_M1 && m1_req) begin
            gnt = 2'b10;
        end else begin
            gnt = pick_gnt;
        end
    end

    // Memory-side mux and burst bookkeeping for the granted master
    always_comb begin
        any_gnt   = |gnt;
        sel       = gnt[1];
        sel_we    = sel ? m1_we   : m0_we;
        sel_lock  = sel ? m1_lock : m0_lock;
        sel_own   = sel ? OWN_M1  : OWN_M0;
        // A fresh owner starts counting from zero, a continuing owner adds on
        base_cnt  = (owner == sel_own) ? beat_cnt : 4'd0;
        next_cnt  = {1'b0, base_cnt} + 5'd1;
        lock_ok   = sel_lock && (next_cnt < 5'(MAX_BURST));
        mem_read  = any_gnt & ~sel_we;
        mem_write = any_gnt &  sel_we;
        mem_addr  = any_gnt ? (sel ? m1_addr  : m0_addr)  : '0;
        mem_wdata = any_gnt ? (sel ? m1_wdata : m0_wdata) : '0;
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Read return is gated by reset so a read in flight is silently dropped;
    // rdata is zero whenever no read is pending, hiding the memory's idle bus.
    assign m0_rvalid = rd_pend & ~rst & ~rd_tag;
    assign m1_rvalid = rd_pend & ~rst &  rd_tag;
    assign rdata     = (rd_pend & ~rst) ? mem_rd : '0;

    // Arbitration state: pointer, lock owner, burst count, read pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            owner    <= OWN_NONE;
            beat_cnt <= 4'd0;
            rd_pend  <= 1'b0;
            rd_tag   <= 1'b0;
        end else if (any_gnt) begin
            rr_ptr  <= ~sel;
            rd_pend <= ~sel_we;
            rd_tag  <= sel;
            if (lock_ok) begin
                owner    <= sel_own;
                beat_cnt <= next_cnt[3:0];
            end else begin
                owner    <= OWN_NONE;
                beat_cnt <= 4'd0;
            end
        end else begin
            // Idle cycle: any lock lapses because its owner stopped asking
            owner    <= OWN_NONE;
            beat_cnt <= 4'd0;
            rd_pend  <= 1'b0;
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter in front of the single-port data memory (`DATA_MEM`). It shares the memory's one read/write port between the CPU load/store path (master 0) and the DMA/loader engine (master 1). Each cycle it grants at most one access and drives `MEMRead`/`MEMWrite`/`ADDR`/`WD`. It returns read data to the granted master with the memory's one-cycle registered latency. Round-robin fairness, plus optional bounded lock bursts for the DMA.

## Interface
- `AW`, 32: address width (byte address; memory uses bits [11:2]).
- `DW`, 32: data width.
- `MAX_BURST`, 4: max consecutive grants one master may hold via `lock`; range 1..15.

- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `m0_req`, `m1_req` in 1 each: access request; held until granted.
- `m0_we`, `m1_we` in 1 each: 1 = write, 0 = read; valid with req.
- `m0_lock`, `m1_lock` in 1 each: request to keep ownership for the next beat.
- `m0_addr`, `m1_addr` in AW each: byte address.
- `m0_wdata`, `m1_wdata` in DW each: write data.
- `m0_gnt`, `m1_gnt` out 1 each: request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid` out 1 each: read data valid (registered).
- `rdata` out DW: read data, shared by both masters.
- `mem_read`, `mem_write` out 1 each: to `MEMRead`, `MEMWrite`.
- `mem_addr` out AW, `mem_wdata` out DW: to `ADDR`, `WD`.
- `mem_rd` in DW: from `RD`.

## Operation
- State registers:
  - `rr_ptr`: 0 = master 0 has priority.
  - `owner`: NONE / M0 / M1 (2-bit).
  - `beat_cnt`: 4-bit.
  - `rd_pend`: 1 bit plus a 1-bit tag naming the master.
- Grant selection, combinational, every cycle:
  - If `owner` != NONE and the owner has `req`=1, grant the owner.
  - Otherwise, if exactly one `req` is high, grant it.
  - If both are high, grant the master selected by `rr_ptr`.
  - At most one of `m0_gnt`/`m1_gnt` is high.
- Memory drive:
  - `mem_read` = gnt & ~we; `mem_write` = gnt & we.
  - `mem_addr`/`mem_wdata` muxed from the granted master.
  - Forced to 0 when no grant.
- On a grant to master m (posedge):
  - `rr_ptr` <= ~m.
  - If `m_lock`=1 and `beat_cnt`+1 < MAX_BURST: `owner` <= m, `beat_cnt` <= `beat_cnt`+1.
  - Otherwise `owner` <= NONE, `beat_cnt` <= 0.
- Owner drops `req` while locked: `owner` <= NONE, `beat_cnt` <= 0; the other master is arbitrated that same cycle.
- Read return:
  - A read grant sets `rd_pend` with tag m for the next cycle only.
  - `m_rvalid` = `rd_pend` & tag==m.
  - `rdata` = `mem_rd` when `rd_pend`, else 0; this masks the memory's Z output.
- Back-to-back reads are fully pipelined, one per cycle.
- Read after write to the same address on the next cycle returns the new data.

## Timing
- Reset values (cycle after `rst` high at posedge): `rr_ptr`=0, `owner`=NONE, `beat_cnt`=0, `rd_pend`=0, all `rvalid`=0, `rdata`=0.
- During `rst`, gnt and `mem_*` outputs are forced 0.
- A request raised in cycle N is granted in N if it wins arbitration. `rvalid` and `rdata` appear in N+1.
- Write completes at the posedge ending cycle N. No write acknowledge beyond `gnt`.
- Masters change addr/we/wdata only after the posedge that samples `gnt`=1.
- Worst-case wait for an unlocked master: 1 + MAX_BURST cycles.
- Reset asserted with `rd_pend`=1: the pending `rvalid` is suppressed and no data is returned.
- `MAX_BURST`=1 disables locking entirely.

## Structure
- Shared package `dmem_pkg`:
  - owner encoding (`OWN_NONE`=2'b00, `OWN_M0`=2'b01, `OWN_M1`=2'b10).
  - default widths `AW`, `DW`.
  - `MAX_BURST` default.
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin picker (req[1:0], ptr → gnt[1:0]).
- Top level holds the owner/beat/rd_pend registers and the memory mux. Memory instance stays outside this block.

## Test plan
- Single read, m0 only: mem[2]=2, m0 reads addr 0x8 → `m0_gnt` same cycle, `m0_rvalid`=1 and `rdata`=2 next cycle, `m1_rvalid`=0.
- Contention after reset, both reads: m0 addr 0x0, m1 addr 0x4 →
  - cycle 0: grant m0.
  - cycle 1: grant m1; `rdata`=1 to m0.
  - cycle 2: `rdata`=9 to m1.
- Write-then-read: m1 writes 0xDEAD to 0x10; next cycle m0 reads 0x10 → `m0_rvalid` with `rdata`=0xDEAD.
- Lock burst, MAX_BURST=4: m1 holds lock+req for 6 beats while m0 requests continuously →
  - m1 granted 4 consecutive cycles.
  - m0 granted in cycle 5.
  - m1 resumes in cycle 6.
- Reset mid-read: read granted in cycle N, `rst`=1 at posedge N+1 → no `rvalid`, `rdata`=0, `rr_ptr`=0 afterwards.
- Idle: no req → `mem_read`=`mem_write`=0, `mem_addr`=0, `rdata`=0 for 10 cycles.
